// File: rtl/inst_dispatcher.sv
// -----------------------------------------------------------------------------
// inst_dispatcher
//
// Instruction fetch/decode/dispatch engine for the systolic-array accelerator.
// Fetches instructions from an external synchronous instruction memory
// starting at a programmable PC. It decodes them into opcode / buffer-id /
// memory-location fields and issues each one over a valid/ready handshake.
// The destination is the load/store unit (LD, ST) or the systolic array
// (GEMM, DRAINSYS).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, start_pc       begin execution at start_pc (IDLE/DONE/ERROR only)
//   imem_en, imem_addr    instruction memory read request (FETCH state)
//   imem_rdata            read data, valid the cycle after imem_en
//   opcode/buf_id/mem_loc decoded fields of the held instruction
//   ldst_valid/ldst_ready handshake to the load/store unit
//   sa_valid/sa_ready     handshake to the systolic array
//   sa_busy               array still has GEMM work outstanding
//   busy, done, err       status; done/err are held until the next start
//   err_code              01 illegal opcode, 10 PC wrap on issue
//   pc, inst_count        current PC, saturating count of issued instructions
//
// Handshake: a valid is raised only in ISSUE. The transfer completes on the
// rising edge where valid && ready. While valid is high the fields are held
// constant, and valid is not withdrawn before acceptance (reset excepted).
// The one exception is the store barrier: an ST is not offered at all while
// sa_busy is high, so it is held back rather than withdrawn.
// -----------------------------------------------------------------------------
module inst_dispatcher #(
    parameter int OPCODE_WIDTH  = 4,
    parameter int BUF_ID_WIDTH  = 2,
    parameter int MEM_LOC_WIDTH = 10,
    parameter int INST_WIDTH    = OPCODE_WIDTH + BUF_ID_WIDTH + MEM_LOC_WIDTH,
    parameter int PC_WIDTH      = 10,
    parameter int CNT_WIDTH     = 16,
    parameter logic [OPCODE_WIDTH-1:0] OP_NOP      = OPCODE_WIDTH'(4'b0000),
    parameter logic [OPCODE_WIDTH-1:0] OP_LD       = OPCODE_WIDTH'(4'b0010),
    parameter logic [OPCODE_WIDTH-1:0] OP_ST       = OPCODE_WIDTH'(4'b0011),
    parameter logic [OPCODE_WIDTH-1:0] OP_GEMM     = OPCODE_WIDTH'(4'b0100),
    parameter logic [OPCODE_WIDTH-1:0] OP_DRAINSYS = OPCODE_WIDTH'(4'b0101),
    parameter logic [OPCODE_WIDTH-1:0] OP_HALT     = OPCODE_WIDTH'(4'b1111)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PC_WIDTH-1:0]      start_pc,
    output logic                     imem_en,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic [INST_WIDTH-1:0]    imem_rdata,
    output logic [OPCODE_WIDTH-1:0]  opcode,
    output logic [BUF_ID_WIDTH-1:0]  buf_id,
    output logic [MEM_LOC_WIDTH-1:0] mem_loc,
    output logic                     ldst_valid,
    input  logic                     ldst_ready,
    output logic                     sa_valid,
    input  logic                     sa_ready,
    input  logic                     sa_busy,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [PC_WIDTH-1:0]      pc,
    output logic [CNT_WIDTH-1:0]     inst_count
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_PC_WRAP = 2'b10;

    localparam logic [PC_WIDTH-1:0]  PC_MAX  = '1;
    localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [2:0] state;

    // -------------------------------------------------------------------------
    // Field extraction from the memory read data (used only in DECODE)
    // -------------------------------------------------------------------------
    logic [OPCODE_WIDTH-1:0]  rd_opcode;
    logic [BUF_ID_WIDTH-1:0]  rd_buf_id;
    logic [MEM_LOC_WIDTH-1:0] rd_mem_loc;
    logic                     rd_is_issue;

    assign rd_opcode  = imem_rdata[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign rd_buf_id  = imem_rdata[MEM_LOC_WIDTH +: BUF_ID_WIDTH];
    assign rd_mem_loc = imem_rdata[MEM_LOC_WIDTH-1:0];

    assign rd_is_issue = (rd_opcode == OP_LD)   || (rd_opcode == OP_ST) ||
                         (rd_opcode == OP_GEMM) || (rd_opcode == OP_DRAINSYS);

    // -------------------------------------------------------------------------
    // Issue handshake (combinational from state + held opcode)
    // -------------------------------------------------------------------------
    logic in_issue;
    logic held_is_sa;
    logic accept;

    assign in_issue   = (state == S_ISSUE);
    assign held_is_sa = (opcode == OP_GEMM) || (opcode == OP_DRAINSYS);

    // A store must not overtake GEMM results still being produced, so ST is
    // only offered while the array reports no outstanding work.
    assign ldst_valid = in_issue &&
                        ((opcode == OP_LD) || ((opcode == OP_ST) && !sa_busy));
    assign sa_valid   = in_issue && held_is_sa;

    assign accept = (ldst_valid && ldst_ready) || (sa_valid && sa_ready);

    // -------------------------------------------------------------------------
    // Memory request and status
    // -------------------------------------------------------------------------
    assign imem_en   = (state == S_FETCH);
    assign imem_addr = imem_en ? pc : '0;

    assign busy = (state == S_FETCH) || (state == S_DECODE) || (state == S_ISSUE);

    // -------------------------------------------------------------------------
    // Main sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            opcode     <= '0;
            buf_id     <= '0;
            mem_loc    <= '0;
            pc         <= '0;
            inst_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        pc         <= start_pc;
                        inst_count <= '0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        err_code   <= ERR_NONE;
                        state      <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    opcode  <= rd_opcode;
                    buf_id  <= rd_buf_id;
                    mem_loc <= rd_mem_loc;
                    if (rd_opcode == OP_NOP) begin
                        // NOP advances with ordinary PC arithmetic (it may wrap).
                        pc    <= pc + PC_ONE;
                        state <= S_FETCH;
                    end else if (rd_opcode == OP_HALT) begin
                        // PC stays on the HALT so software can see where it stopped.
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (rd_is_issue) begin
                        state <= S_ISSUE;
                    end else begin
                        err      <= 1'b1;
                        err_code <= ERR_ILLEGAL;
                        state    <= S_ERROR;
                    end
                end

                S_ISSUE: begin
                    if (accept) begin
                        if (inst_count != CNT_MAX) begin
                            inst_count <= inst_count + CNT_ONE;
                        end
                        // An issue from the last address would need the PC to
                        // wrap; stop there instead of running into address 0.
                        if (pc == PC_MAX) begin
                            err      <= 1'b1;
                            err_code <= ERR_PC_WRAP;
                            state    <= S_ERROR;
                        end else begin
                            pc    <= pc + PC_ONE;
                            state <= S_FETCH;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_inst_dispatcher
//
// Self-checking bench for inst_dispatcher. A behavioural program-walk model
// computes, from the memory contents, the list of instructions that must be
// issued and the final pc / count / done / err state. A per-cycle monitor
// compares each completed handshake against the expected queue.
// -----------------------------------------------------------------------------
module tb_inst_dispatcher;

    localparam int OPW = 4;
    localparam int BW  = 2;
    localparam int LW  = 10;
    localparam int IW  = 16;
    localparam int PW  = 10;
    localparam int CW  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1 (default widths) ----------------
    logic            start = 1'b0;
    logic [PW-1:0]   start_pc = '0;
    logic            imem_en;
    logic [PW-1:0]   imem_addr;
    logic [IW-1:0]   imem_rdata = '0;
    logic [OPW-1:0]  opcode;
    logic [BW-1:0]   buf_id;
    logic [LW-1:0]   mem_loc;
    logic            ldst_valid;
    logic            ldst_ready = 1'b0;
    logic            sa_valid;
    logic            sa_ready = 1'b0;
    logic            sa_busy = 1'b0;
    logic            busy;
    logic            done;
    logic            err;
    logic [1:0]      err_code;
    logic [PW-1:0]   pc;
    logic [CW-1:0]   inst_count;

    inst_dispatcher dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .opcode(opcode), .buf_id(buf_id), .mem_loc(mem_loc),
        .ldst_valid(ldst_valid), .ldst_ready(ldst_ready),
        .sa_valid(sa_valid), .sa_ready(sa_ready), .sa_busy(sa_busy),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .pc(pc), .inst_count(inst_count)
    );

    // ---------------- DUT 2 (2-bit counter for saturation) ----------------
    logic            start2 = 1'b0;
    logic            imem_en2;
    logic [PW-1:0]   imem_addr2;
    logic [IW-1:0]   imem_rdata2 = '0;
    logic [OPW-1:0]  opcode2;
    logic [BW-1:0]   buf_id2;
    logic [LW-1:0]   mem_loc2;
    logic            ldst_valid2;
    logic            sa_valid2;
    logic            busy2;
    logic            done2;
    logic            err2;
    logic [1:0]      err_code2;
    logic [PW-1:0]   pc2;
    logic [1:0]      inst_count2;

    inst_dispatcher #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .start_pc(start_pc),
        .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .opcode(opcode2), .buf_id(buf_id2), .mem_loc(mem_loc2),
        .ldst_valid(ldst_valid2), .ldst_ready(ldst_ready),
        .sa_valid(sa_valid2), .sa_ready(sa_ready), .sa_busy(sa_busy),
        .busy(busy2), .done(done2), .err(err2), .err_code(err_code2),
        .pc(pc2), .inst_count(inst_count2)
    );

    // ---------------- instruction memory model ----------------
    logic [IW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (imem_en)  imem_rdata  <= mem[imem_addr];
        if (imem_en2) imem_rdata2 <= mem[imem_addr2];
    end

    // ---------------- scoreboard state ----------------
    logic [IW-1:0] exp_q[$];
    int            issue_cyc[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            n_issued = 0;
    int            vhi_cnt = 0;
    int            n_start = 0;
    bit            mon_en = 1'b0;
    bit            prev_pend = 1'b0;
    bit            last_gemm_acc = 1'b0;
    logic [IW+1:0] prev_snap = '0;

    function automatic logic [IW-1:0] mk(input int op, input int b, input int loc);
        logic [IW-1:0] w;
        w = {4'(op), 2'(b), 10'(loc)};
        return w;
    endfunction

    // Reference model: walk the program as the architecture defines it.
    task automatic model_run(input int spc, input int cw, input bit push,
                             output int fpc, output int fcnt, output int fdone,
                             output int ferr, output int fcode);
        int p, c, cmax, op;
        p = spc; c = 0; cmax = (1 << cw) - 1;
        fdone = 0; ferr = 0; fcode = 0;
        for (int s = 0; s < 4096; s++) begin
            op = int'(mem[p][15:12]);
            if (op == 0) begin
                p = (p + 1) % 1024;
            end else if (op == 15) begin
                fdone = 1;
                break;
            end else if (op >= 2 && op <= 5) begin
                if (push) exp_q.push_back(mem[p]);
                if (c < cmax) c = c + 1;
                if (p == 1023) begin
                    ferr = 1; fcode = 2;
                    break;
                end
                p = p + 1;
            end else begin
                ferr = 1; fcode = 1;
                break;
            end
        end
        fpc = p; fcnt = c;
    endtask

    // One clock cycle: observe at the falling edge, return 1 after the rise.
    task automatic tick();
        logic acc;
        logic [1:0] exp_v;
        logic [IW-1:0] e;
        logic [IW+1:0] snap;
        @(negedge clk);
        last_gemm_acc = 1'b0;
        if (mon_en) begin
            snap = {ldst_valid, sa_valid, opcode, buf_id, mem_loc};
            checks++;
            if (ldst_valid && sa_valid) begin
                errors++;
                $display("FAIL one_valid: ldst_valid=%0b sa_valid=%0b, at most one allowed",
                         ldst_valid, sa_valid);
            end
            if (prev_pend) begin
                checks++;
                if (snap !== prev_snap) begin
                    errors++;
                    $display("FAIL hold_until_accept: got %h expected %h", snap, prev_snap);
                end
            end
            acc = (ldst_valid && ldst_ready) || (sa_valid && sa_ready);
            if (acc) begin
                n_issued++;
                issue_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue: got %h expected none", snap);
                end else begin
                    e = exp_q.pop_front();
                    exp_v = (e[15:12] == 4'd2 || e[15:12] == 4'd3) ? 2'b10 : 2'b01;
                    if (snap !== {exp_v, e}) begin
                        errors++;
                        $display("FAIL issue: got %h expected %h", snap, {exp_v, e});
                    end
                end
                if (opcode == 4'd4) last_gemm_acc = 1'b1;
            end
            if (ldst_valid || sa_valid) vhi_cnt++;
            prev_pend = (ldst_valid || sa_valid) && !acc;
            prev_snap = snap;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_start(input int spc);
        start_pc = PW'(spc);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_start = cyc;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles expected 0", busy, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        checks++;
        if ({opcode, buf_id, mem_loc, ldst_valid, sa_valid, imem_en, imem_addr,
             pc, inst_count, done, err, err_code, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: pc=%0d cnt=%0d op=%0d done=%0b err=%0b expected all 0",
                     pc, inst_count, opcode, done, err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_sequence();
        int fpc, fcnt, fdone, ferr, fcode;
        mem[0] = mk(2, 1, 5); mem[1] = mk(4, 0, 0); mem[2] = mk(3, 2, 9); mem[3] = mk(15, 0, 0);
        ldst_ready = 1; sa_ready = 1; sa_busy = 0;
        model_run(0, CW, 1, fpc, fcnt, fdone, ferr, fcode);
        issue_cyc.delete();
        vhi_cnt = 0;
        do_start(0);
        run_until_idle(50);
        checks++;
        if (issue_cyc.size() != 3) begin
            errors++;
            $display("FAIL seq_issue_count: got %0d expected 3", issue_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (issue_cyc[i] != n_start + 2 + 3 * i) begin
                    errors++;
                    $display("FAIL seq_issue_cycle%0d: got %0d expected %0d",
                             i, issue_cyc[i] - n_start, 2 + 3 * i);
                end
            end
        end
        checks++;
        if (vhi_cnt != 3) begin
            errors++;
            $display("FAIL seq_valid_cycles: got %0d expected 3", vhi_cnt);
        end
        checks++;
        if ({done, err, pc, inst_count} !== {1'(fdone), 1'(ferr), PW'(fpc), CW'(fcnt)} ||
            fpc != 3 || fcnt != 3) begin
            errors++;
            $display("FAIL seq_final: done=%0b pc=%0d cnt=%0d expected done=1 pc=3 cnt=3",
                     done, pc, inst_count);
        end
    endtask

    task automatic test_st_barrier();
        int fpc, fcnt, fdone, ferr, fcode, n;
        mem[0] = mk(4, 0, 0); mem[1] = mk(3, 2, 9); mem[2] = mk(15, 0, 0);
        ldst_ready = 1; sa_ready = 1; sa_busy = 0;
        model_run(0, CW, 1, fpc, fcnt, fdone, ferr, fcode);
        do_start(0);
        n = 0;
        tick();
        while (!last_gemm_acc && n < 20) begin
            tick();
            n++;
        end
        sa_busy = 1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ldst_valid !== 1'b0) begin
                errors++;
                $display("FAIL barrier_hold%0d: ldst_valid=%0b expected 0", i, ldst_valid);
            end
            if (i >= 3) begin
                checks++;
                if ({opcode, buf_id, mem_loc} !== mk(3, 2, 9)) begin
                    errors++;
                    $display("FAIL barrier_fields%0d: got %h expected %h",
                             i, {opcode, buf_id, mem_loc}, mk(3, 2, 9));
                end
            end
            tick();
        end
        sa_busy = 0;
        #1;
        checks++;
        if (ldst_valid !== 1'b1) begin
            errors++;
            $display("FAIL barrier_release: ldst_valid=%0b expected 1", ldst_valid);
        end
        run_until_idle(50);
        checks++;
        if (done !== 1'b1 || pc !== PW'(fpc) || inst_count !== CW'(fcnt) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL barrier_final: done=%0b pc=%0d cnt=%0d left=%0d expected 1 %0d %0d 0",
                     done, pc, inst_count, exp_q.size(), fpc, fcnt);
        end
    endtask

    task automatic test_sa_backpressure();
        int fpc, fcnt, fdone, ferr, fcode, hi, n;
        mem[0] = mk(4, 1, 341); mem[1] = mk(15, 0, 0);
        ldst_ready = 1; sa_ready = 0; sa_busy = 0;
        model_run(0, CW, 1, fpc, fcnt, fdone, ferr, fcode);
        do_start(0);
        hi = 0; n = 0;
        while (busy && n < 40) begin
            if (sa_valid) begin
                hi++;
                checks++;
                if (pc !== '0 || inst_count !== '0) begin
                    errors++;
                    $display("FAIL bp_pc_hold: pc=%0d cnt=%0d expected 0 0", pc, inst_count);
                end
                if (hi == 8) sa_ready = 1;
            end
            tick();
            n++;
        end
        sa_ready = 1;
        checks++;
        if (hi != 8) begin
            errors++;
            $display("FAIL bp_valid_cycles: got %0d expected 8", hi);
        end
        checks++;
        if (inst_count !== CW'(fcnt) || fcnt != 1 || pc !== PW'(fpc) || done !== 1'b1) begin
            errors++;
            $display("FAIL bp_final: cnt=%0d pc=%0d done=%0b expected 1 1 1", inst_count, pc, done);
        end
    endtask

    task automatic test_illegal();
        int fpc, fcnt, fdone, ferr, fcode;
        mem[0] = mk(0, 0, 0); mem[1] = mk(0, 0, 0); mem[2] = mk(7, 1, 1); mem[3] = mk(15, 0, 0);
        ldst_ready = 1; sa_ready = 1; sa_busy = 0;
        model_run(0, CW, 1, fpc, fcnt, fdone, ferr, fcode);
        vhi_cnt = 0;
        do_start(0);
        run_until_idle(50);
        checks++;
        if (vhi_cnt != 0) begin
            errors++;
            $display("FAIL illegal_no_valid: valid cycles=%0d expected 0", vhi_cnt);
        end
        checks++;
        if ({err, err_code, pc, busy, done} !== {1'(ferr), 2'(fcode), PW'(fpc), 1'b0, 1'(fdone)} ||
            fcode != 1 || fpc != 2) begin
            errors++;
            $display("FAIL illegal_final: err=%0b code=%0d pc=%0d busy=%0b expected 1 1 2 0",
                     err, err_code, pc, busy);
        end
        model_run(3, CW, 1, fpc, fcnt, fdone, ferr, fcode);
        do_start(3);
        checks++;
        if (err !== 1'b0 || err_code !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL illegal_restart: err=%0b code=%0d busy=%0b expected 0 0 1",
                     err, err_code, busy);
        end
        run_until_idle(50);
        checks++;
        if (done !== 1'b1 || pc !== PW'(fpc)) begin
            errors++;
            $display("FAIL illegal_rerun: done=%0b pc=%0d expected 1 %0d", done, pc, fpc);
        end
    endtask

    task automatic test_pc_wrap();
        int fpc, fcnt, fdone, ferr, fcode;
        mem[1023] = mk(2, 3, 1023);
        ldst_ready = 1; sa_ready = 1; sa_busy = 0;
        model_run(1023, CW, 1, fpc, fcnt, fdone, ferr, fcode);
        do_start(1023);
        run_until_idle(50);
        checks++;
        if ({err, err_code, pc, inst_count} !== {1'(ferr), 2'(fcode), PW'(fpc), CW'(fcnt)} ||
            fcode != 2 || fpc != 1023 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_final: err=%0b code=%0d pc=%0d cnt=%0d expected 1 2 1023 1",
                     err, err_code, pc, inst_count);
        end
    endtask

    task automatic test_reset_in_issue();
        int n;
        mem[0] = mk(2, 1, 7); mem[1] = mk(15, 0, 0);
        ldst_ready = 0; sa_ready = 1; sa_busy = 0;
        do_start(0);
        n = 0;
        while (!ldst_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (ldst_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_reach_issue: ldst_valid=%0b expected 1", ldst_valid);
        end
        mon_en = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({opcode, buf_id, mem_loc, ldst_valid, sa_valid, imem_en, imem_addr,
             pc, inst_count, done, err, err_code, busy} !== '0) begin
            errors++;
            $display("FAIL rst_async: ldst_valid=%0b pc=%0d op=%0d busy=%0b expected all 0",
                     ldst_valid, pc, opcode, busy);
        end
        exp_q.delete();
        prev_pend = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ldst_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || ldst_valid !== 1'b0 || inst_count !== '0) begin
                errors++;
                $display("FAIL rst_idle%0d: busy=%0b ldst_valid=%0b cnt=%0d expected 0 0 0",
                         i, busy, ldst_valid, inst_count);
            end
        end
        mon_en = 1;
    endtask

    task automatic test_start_while_busy();
        int fpc, fcnt, fdone, ferr, fcode, n;
        mem[0] = mk(2, 2, 3); mem[1] = mk(15, 0, 0);
        ldst_ready = 0; sa_ready = 1; sa_busy = 0;
        model_run(0, CW, 1, fpc, fcnt, fdone, ferr, fcode);
        do_start(0);
        n = 0;
        while (!ldst_valid && n < 10) begin
            tick();
            n++;
        end
        start_pc = 10'd500;
        start = 1;
        tick();
        tick();
        start = 0;
        checks++;
        if (pc !== '0 || inst_count !== '0 || ldst_valid !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: pc=%0d cnt=%0d ldst_valid=%0b expected 0 0 1",
                     pc, inst_count, ldst_valid);
        end
        ldst_ready = 1;
        run_until_idle(50);
        checks++;
        if (pc !== PW'(fpc) || inst_count !== CW'(fcnt) || done !== 1'(fdone)) begin
            errors++;
            $display("FAIL start_ignored_final: pc=%0d cnt=%0d done=%0b expected %0d %0d %0d",
                     pc, inst_count, done, fpc, fcnt, fdone);
        end
    endtask

    task automatic test_saturation();
        int fpc, fcnt, fdone, ferr, fcode, n;
        for (int i = 0; i < 5; i++) mem[i] = mk(2, 0, i);
        mem[5] = mk(15, 0, 0);
        ldst_ready = 1; sa_ready = 1; sa_busy = 0;
        model_run(0, 2, 0, fpc, fcnt, fdone, ferr, fcode);
        start_pc = '0;
        start2 = 1;
        tick();
        start2 = 0;
        n = 0;
        while (busy2 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (inst_count2 !== 2'(fcnt) || fcnt != 3 || pc2 !== PW'(fpc) || done2 !== 1'b1) begin
            errors++;
            $display("FAIL saturation: cnt=%0d pc=%0d done=%0b expected 3 5 1",
                     inst_count2, pc2, done2);
        end
    endtask

    task automatic test_random();
        int fpc, fcnt, fdone, ferr, fcode, base, len, op, r, n, busy_left;
        for (int t = 0; t < 24; t++) begin
            len = $urandom_range(1, 10);
            base = (t % 4 == 3) ? 1024 - len : $urandom_range(0, 1000);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                op = (r < 2) ? 0 : (r < 4) ? 2 : (r < 6) ? 3 : (r < 8) ? 4 : 5;
                mem[(base + i) % 1024] = mk(op, $urandom_range(0, 3), $urandom_range(0, 1023));
            end
            if (t % 4 == 3) mem[1023] = mk(4, $urandom_range(0, 3), $urandom_range(0, 1023));
            op = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 14) : 15;
            mem[(base + len) % 1024] = mk(op, 0, 0);
            sa_busy = 0;
            busy_left = 0;
            model_run(base, CW, 1, fpc, fcnt, fdone, ferr, fcode);
            do_start(base);
            n = 0;
            while (busy && n < 3000) begin
                ldst_ready = ($urandom_range(0, 3) != 0);
                sa_ready = ($urandom_range(0, 3) != 0);
                tick();
                if (last_gemm_acc) busy_left = $urandom_range(0, 6);
                else if (busy_left > 0) busy_left--;
                sa_busy = (busy_left > 0);
                n++;
            end
            checks++;
            if ({busy, done, err, err_code, pc, inst_count} !==
                {1'b0, 1'(fdone), 1'(ferr), 2'(fcode), PW'(fpc), CW'(fcnt)} || exp_q.size() != 0) begin
                errors++;
                $display("FAIL random%0d: busy=%0b done=%0b err=%0b code=%0d pc=%0d cnt=%0d left=%0d expected 0 %0d %0d %0d %0d %0d 0",
                         t, busy, done, err, err_code, pc, inst_count, exp_q.size(),
                         fdone, ferr, fcode, fpc, fcnt);
            end
            exp_q.delete();
        end
        sa_busy = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'hF000;
        test_reset();
        test_sequence();
        test_st_barrier();
        test_sa_backpressure();
        test_illegal();
        test_pc_wrap();
        test_reset_in_issue();
        test_start_while_busy();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_dispatcher.md
Name: inst_dispatcher

Overview:
Parametrised instruction fetch/decode/dispatch engine for the systolic-array accelerator. It fetches instructions from an external synchronous instruction memory starting at a programmable PC. It decodes the opcode, buffer-id and memory-location fields, and issues each instruction over valid/ready handshakes to the load/store unit (LD, ST) or the systolic array (GEMM, DRAINSYS). It adds start/done control, HALT/NOP, a store-after-GEMM barrier and error reporting.

Parameters:
OPCODE_WIDTH, 4, opcode field width (MSBs of instruction)
BUF_ID_WIDTH, 2, buffer-id field width
MEM_LOC_WIDTH, 10, memory-location field width (LSBs)
INST_WIDTH, OPCODE_WIDTH+BUF_ID_WIDTH+MEM_LOC_WIDTH, instruction width
PC_WIDTH, 10, instruction address width (memory depth 2^PC_WIDTH)
CNT_WIDTH, 16, issued-instruction counter width
OP_NOP / OP_LD / OP_ST / OP_GEMM / OP_DRAINSYS / OP_HALT, 0000 / 0010 / 0011 / 0100 / 0101 / 1111, opcode encodings

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin execution (sampled in IDLE, DONE or ERROR only)
start_pc  in  PC_WIDTH  first instruction address
imem_en  out  1  instruction memory read enable
imem_addr  out  PC_WIDTH  read address
imem_rdata  in  INST_WIDTH  read data, valid the cycle after imem_en
opcode  out  OPCODE_WIDTH  decoded opcode of held instruction
buf_id  out  BUF_ID_WIDTH  decoded buffer id
mem_loc  out  MEM_LOC_WIDTH  decoded memory location
ldst_valid  out  1  LD/ST instruction offered
ldst_ready  in  1  load/store unit accepts
sa_valid  out  1  GEMM/DRAINSYS instruction offered
sa_ready  in  1  systolic array accepts
sa_busy  in  1  array has GEMM work outstanding
busy  out  1  state not IDLE/DONE/ERROR
done  out  1  HALT reached; held until next start
err  out  1  error; held until next start
err_code  out  2  01 illegal opcode, 10 PC wrap
pc  out  PC_WIDTH  current PC
inst_count  out  CNT_WIDTH  instructions issued (NOP/HALT excluded), saturating

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: opcode, buf_id, mem_loc, valids, imem_en, imem_addr, pc, inst_count, done, err, err_code. Reset mid-handshake drops valid immediately; no instruction is considered issued.
- States: IDLE, FETCH, DECODE, ISSUE, DONE, ERROR.
- IDLE/DONE/ERROR + start=1: pc<=start_pc, inst_count<=0, done<=0, err<=0, err_code<=0 -> FETCH. start is ignored while busy.
- FETCH: imem_en=1, imem_addr=pc (combinational from state) -> DECODE.
- DECODE: latch imem_rdata into opcode/buf_id/mem_loc.
  - NOP: pc+1, -> FETCH.
  - HALT: done<=1 -> DONE; pc is not incremented.
  - LD/ST/GEMM/DRAINSYS: -> ISSUE.
  - Any other opcode: err<=1, err_code<=01 -> ERROR.
- ISSUE:
  - LD/ST drive ldst_valid; GEMM/DRAINSYS drive sa_valid. Exactly one valid is high; valids are combinational from state+opcode.
  - Barrier: ST asserts ldst_valid only while sa_busy=0.
  - Handshake completes on the clock edge where valid&&ready. Fields are stable while valid is high, and valid never drops before acceptance (except reset).
  - On completion: inst_count+1 (saturates at all-ones), then check pc:
    - pc==2^PC_WIDTH-1: err<=1, err_code<=10 -> ERROR; pc is not wrapped.
    - Otherwise pc+1 -> FETCH.
- Timing: start sampled at edge N -> FETCH; DECODE at N+1; ISSUE (valid high) during the cycle after edge N+2. Back-to-back instructions with ready tied high: one issue every 3 cycles.
- NOP/HALT/illegal opcodes never assert a valid.
- busy=1 in FETCH, DECODE, ISSUE.

Test Plan:
1. Memory holds LD b1 @5, GEMM b0 @0, ST b2 @9, HALT at 0..3; start_pc=0; ready=1, sa_busy=0 -> ldst_valid, sa_valid, ldst_valid, each exactly 1 cycle, 3 cycles apart with fields (2,1,5),(4,0,0),(3,2,9); done=1, pc=3, inst_count=3.
2. GEMM then ST; sa_busy=1 for 10 cycles after GEMM acceptance -> ldst_valid stays 0 for those cycles and rises the cycle sa_busy falls; fields stable throughout.
3. sa_ready held 0 for 7 cycles on GEMM -> sa_valid stays high 8 cycles; pc unchanged until acceptance; inst_count increments once.
4. Opcode 0111 at addr 2 after NOP,NOP -> no valid ever asserted; err=1, err_code=01, pc=2, busy=0; new start clears err.
5. start_pc=1023, instruction LD -> issued, then err_code=10, pc=1023. Separately: rst_n low during ISSUE -> all outputs 0 asynchronously, state IDLE.
6. start pulsed while in ISSUE -> ignored (pc and inst_count unaffected); inst_count saturation checked with CNT_WIDTH=2 and 5 issues -> 3.
